v_channel_seq: RTL
==================

V_CHANNEL_SEQ -- requirements
Module: v_channel_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter LEN_W, default 32, transfer-length width in bytes.
REQ-003 SHALL have parameter BUFFER_SIZE, default 4, channel buffer depth in 32-bit words (capacity CAP = 4*BUFFER_SIZE bytes).
REQ-004 SHALL have ports `clk`, in, 1, clock; `areset`, in, 1, reset. Reset is synchronous and active-high.
REQ-005 SHALL have ports `ch_enable_i`, in, 1, start; `ch_abort_i`, in, 1, abort (used only with the macro).
REQ-006 SHALL have ports `ch_rd_addr_i`/`ch_wr_addr_i`, in, ADDR_W, start addresses; `ch_data_len_i`, in, LEN_W, bytes.
REQ-007 SHALL have ports `ch_rd_size_i`/`ch_wr_size_i`, in, 2, log2 beat bytes; `ch_rd_bsize_i`/`ch_wr_bsize_i`, in, 3, log2 beats per burst; `ch_rd_incr_i`/`ch_wr_incr_i`, in, 1, address increment.
REQ-008 SHALL have ports `i_next_i`, in, 1, burst accepted; `i_last_i`/`i_last_write_i`, in, 1, read/write burst complete; `i_resp_i`, in, 1, bus error.
REQ-009 SHALL have ports `rush_read_o`/`rush_write_o`, out, 1, burst request; `i_rd_addr_o`/`i_wr_addr_o`, out, ADDR_W; `i_lenght_o`, out, $clog2(CAP)+1, beats; `i_size_o`, out, 2; `i_incr_o`, out, 1; `i_mode_o`, out, 1 (0 read, 1 write).
REQ-010 SHALL have ports `ch_error_o`, `ch_bus_error_o`, `ch_interrupt_o`, `ready`, all out, 1.

Function
REQ-011 SHALL implement states IDLE, CHECK, READ, WAIT_LAST_READ, WRITE, WAIT_LAST_WRITE, DONE, BUS_ERROR, and ABORT (ABORT only with the macro).
REQ-012 SHALL latch all ch_* configuration and go IDLE->CHECK on a rising edge of `ch_enable_i` while in IDLE; a level held high after completion SHALL NOT restart the channel.
REQ-013 SHALL define RB = 2^rd_bsize << rd_size bytes and WB = 2^wr_bsize << wr_size bytes.
REQ-014 SHALL, in CHECK, go to BUS_ERROR with `ch_error_o` pulsed for 1 cycle if len==0, RB>CAP, WB>CAP, or len is not a multiple of max(1<<rd_size, 1<<wr_size); otherwise it SHALL go to the scheduler.
REQ-015 SHALL track `rd_rem`, `wr_rem` (LEN_W bits, init len) and `fill` (0..CAP bytes).
REQ-016 SHALL schedule in this order: if fill>=min(WB,wr_rem) and wr_rem>0, go WRITE; else if rd_rem>0 and CAP-fill>=min(RB,rd_rem), go READ; else if wr_rem==0, go DONE.
REQ-017 SHALL keep exactly one burst outstanding, with no overlap of read and write.
REQ-018 SHALL make the burst length in bytes min(RB,rd_rem) or min(WB,wr_rem); `i_lenght_o` SHALL be that value >> size, so the final residual burst is shortened.
REQ-019 SHALL hold the request in READ/WRITE until `i_next_i`; it SHALL then move to WAIT_LAST_*, advance the address by the burst bytes if incr (else hold it), and decrement rd_rem/wr_rem.
REQ-020 SHALL, in WAIT_LAST_READ on `i_last_i`, do fill += burst bytes and re-schedule.
REQ-021 SHALL, in WAIT_LAST_WRITE on `i_last_write_i`, do fill -= burst bytes and re-schedule.
REQ-022 SHALL go to BUS_ERROR when `i_resp_i` is high in READ, WRITE, or WAIT_LAST_*, taking priority over `i_next_i` and `i_last*` in the same cycle.
REQ-023 SHALL, in BUS_ERROR, pulse `ch_bus_error_o` for 1 cycle and go to IDLE; in DONE it SHALL pulse `ch_interrupt_o` for 1 cycle and go to IDLE.
REQ-024 SHALL assert `rush_read_o` only in READ and `rush_write_o` only in WRITE; `ready` SHALL be high only in IDLE.
REQ-025 SHALL perform address arithmetic modulo 2^ADDR_W, wrapping silently.

Reset
REQ-026 SHALL, on `areset` high at a clock edge (including mid-burst), set state=IDLE, all counters 0, and all outputs 0 except `ready`=1.
REQ-027 SHALL NOT treat an `i_last*` arriving after reset as a completion.

Configuration
REQ-028 SHALL, with `V_CHANNEL_ABORT_EN` defined, go to ABORT when `ch_abort_i` is high in any non-IDLE state; ABORT SHALL wait for an outstanding `i_last*` (or go immediately if none), then pulse `ch_interrupt_o` and `ch_bus_error_o` together and go to IDLE.
REQ-029 SHALL, without the macro, ignore `ch_abort_i` and exclude the ABORT state.

Structure
REQ-030 SHALL put the state enum and a burst-bytes helper function in package `v_dma_pkg`.
REQ-031 SHALL contain no sub-module; buffer storage (`v_ch_fifo`) SHALL be instantiated by the parent.

Verification
REQ-032 SHALL cover: BUFFER_SIZE=4, rd size2/bsize1, wr size2/bsize2, len=24, rd 0x100, wr 0x200 -> reads at 0x100, 0x108, writes at 0x200 (len 4), read at 0x110, write at 0x210 with `i_lenght_o`=2, then `ch_interrupt_o` pulse.
REQ-033 SHALL cover: len=0 -> `ch_error_o` pulse 2 cycles after enable, no `rush_*`.
REQ-034 SHALL cover: rd bsize=3, size2 (RB=32 > CAP=16) -> config error.
REQ-035 SHALL cover: `i_resp_i` together with `i_next_i` on the 2nd read -> `ch_bus_error_o` pulse and no address advance.
REQ-036 SHALL cover: `areset` during WAIT_LAST_WRITE, then `i_last_write_i` -> remains IDLE and `ready`=1.
REQ-037 SHALL cover, with `V_CHANNEL_ABORT_EN` defined: abort in WAIT_LAST_READ -> ABORT until `i_last_i`, then both pulses and IDLE.

Source files
------------

// File: rtl/v_dma_pkg.sv
// ---------------------------------------------------------------------------
// v_dma_pkg
// Shared types and helpers for the DMA channel sequencer.
//   ch_state_e  : sequencer state encoding (ST_ABORT exists only when the
//                 V_CHANNEL_ABORT_EN macro is defined)
//   BB_W        : width of a burst-bytes value (max 2^7 beats << 3 = 1024)
//   burst_bytes : bytes moved by one full burst, (2^bsize) << size
// ---------------------------------------------------------------------------
package v_dma_pkg;

    typedef enum logic [3:0] {
        ST_IDLE            = 4'd0,
        ST_CHECK           = 4'd1,
        ST_READ            = 4'd2,
        ST_WAIT_LAST_READ  = 4'd3,
        ST_WRITE           = 4'd4,
        ST_WAIT_LAST_WRITE = 4'd5,
        ST_DONE            = 4'd6,
        ST_BUS_ERROR       = 4'd7
`ifdef V_CHANNEL_ABORT_EN
        ,
        ST_ABORT           = 4'd8
`endif
    } ch_state_e;

    localparam int BB_W = 11;

    function automatic logic [BB_W-1:0] burst_bytes(input logic [2:0] bsize,
                                                    input logic [1:0] size);
        logic [BB_W-1:0] beats;
        beats       = 11'd1 << bsize;
        burst_bytes = beats << size;
    endfunction

endpackage

// File: rtl/v_channel_seq.sv
// ---------------------------------------------------------------------------
// v_channel_seq
// One DMA channel sequencer: moves ch_data_len_i bytes from a read address to
// a write address through a channel buffer of CAP = 4*BUFFER_SIZE bytes,
// issuing one read or write burst at a time.
//
// Optional feature: define V_CHANNEL_ABORT_EN to honour ch_abort_i (ABORT
// state). Without it ch_abort_i is ignored.
//
// Ports
//   clk, areset (sync, active high)
//   ch_enable_i (rising edge starts), ch_abort_i
//   ch_rd_addr_i / ch_wr_addr_i, ch_data_len_i          : transfer setup
//   ch_rd_size_i / ch_wr_size_i   : log2 bytes per beat
//   ch_rd_bsize_i / ch_wr_bsize_i : log2 beats per burst
//   ch_rd_incr_i / ch_wr_incr_i   : advance address per burst
//   i_next_i (burst accepted), i_last_i / i_last_write_i (burst finished),
//   i_resp_i (bus error)
//   rush_read_o / rush_write_o    : burst request
//   i_rd_addr_o, i_wr_addr_o, i_lenght_o (beats), i_size_o, i_incr_o,
//   i_mode_o (0 read, 1 write)
//   ch_error_o (config error), ch_bus_error_o, ch_interrupt_o, ready
// All outputs are registered.
// ---------------------------------------------------------------------------
module v_channel_seq
    import v_dma_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32,
    parameter int BUFFER_SIZE = 4
) (
    input  logic                                 clk,
    input  logic                                 areset,
    input  logic                                 ch_enable_i,
    input  logic                                 ch_abort_i,
    input  logic [ADDR_W-1:0]                    ch_rd_addr_i,
    input  logic [ADDR_W-1:0]                    ch_wr_addr_i,
    input  logic [LEN_W-1:0]                     ch_data_len_i,
    input  logic [1:0]                           ch_rd_size_i,
    input  logic [1:0]                           ch_wr_size_i,
    input  logic [2:0]                           ch_rd_bsize_i,
    input  logic [2:0]                           ch_wr_bsize_i,
    input  logic                                 ch_rd_incr_i,
    input  logic                                 ch_wr_incr_i,
    input  logic                                 i_next_i,
    input  logic                                 i_last_i,
    input  logic                                 i_last_write_i,
    input  logic                                 i_resp_i,
    output logic                                 rush_read_o,
    output logic                                 rush_write_o,
    output logic [ADDR_W-1:0]                    i_rd_addr_o,
    output logic [ADDR_W-1:0]                    i_wr_addr_o,
    output logic [$clog2(4*BUFFER_SIZE):0]       i_lenght_o,
    output logic [1:0]                           i_size_o,
    output logic                                 i_incr_o,
    output logic                                 i_mode_o,
    output logic                                 ch_error_o,
    output logic                                 ch_bus_error_o,
    output logic                                 ch_interrupt_o,
    output logic                                 ready
);

    localparam int CAP   = 4 * BUFFER_SIZE;
    localparam int CNT_W = $clog2(CAP) + 1;
    localparam int CMP_W = ((LEN_W > BB_W) ? LEN_W : BB_W) + 1;
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // State and latched configuration
    ch_state_e         state_q, state_d;
    logic              en_prev_q, en_prev_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        rd_size_q, rd_size_d, wr_size_q, wr_size_d;
    logic [2:0]        rd_bsize_q, rd_bsize_d, wr_bsize_q, wr_bsize_d;
    logic              rd_incr_q, rd_incr_d, wr_incr_q, wr_incr_d;
    logic [LEN_W-1:0]  rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  burst_q, burst_d;

    // Registered outputs
    logic              rush_read_q, rush_read_d, rush_write_q, rush_write_d;
    logic [CNT_W-1:0]  lenght_q, lenght_d;
    logic [1:0]        size_q, size_d;
    logic              incr_q, incr_d, mode_q, mode_d;
    logic              ch_error_q, ch_error_d;
    logic              bus_err_q, bus_err_d;
    logic              intr_q, intr_d;
    logic              ready_q, ready_d;

    // Combinational helpers
    logic [BB_W-1:0]   rb_s, wb_s;
    logic [CNT_W-1:0]  rd_burst_s, wr_burst_s, fill_sched_s;
    logic [1:0]        beat_size_s;
    logic [LEN_W-1:0]  align_mask_s;
    logic              cfg_bad_s, wr_go_s, rd_go_s, do_sched_s, abort_done_s;

`ifdef V_CHANNEL_ABORT_EN
    logic              pend_q, pend_d, pend_mode_q, pend_mode_d;
`else
    logic              abort_unused_s;
    assign abort_unused_s = ch_abort_i;
`endif

    // Burst geometry, config validation and scheduler decisions.
    always_comb begin
        rb_s = burst_bytes(rd_bsize_q, rd_size_q);
        wb_s = burst_bytes(wr_bsize_q, wr_size_q);

        // Residual clipping: the last burst only moves what remains.
        if (CMP_W'(rd_rem_q) < CMP_W'(rb_s)) begin
            rd_burst_s = CNT_W'(rd_rem_q);
        end else begin
            rd_burst_s = CNT_W'(rb_s);
        end
        if (CMP_W'(wr_rem_q) < CMP_W'(wb_s)) begin
            wr_burst_s = CNT_W'(wr_rem_q);
        end else begin
            wr_burst_s = CNT_W'(wb_s);
        end

        if (rd_size_q > wr_size_q) begin
            beat_size_s = rd_size_q;
        end else begin
            beat_size_s = wr_size_q;
        end
        align_mask_s = (LEN_ONE << beat_size_s) - LEN_ONE;

        // Only consumed in CHECK, where rd_rem_q still holds the full length.
        cfg_bad_s = (rd_rem_q == LEN_ZERO)
                 || (CMP_W'(rb_s) > CMP_W'(CAP))
                 || (CMP_W'(wb_s) > CMP_W'(CAP))
                 || ((rd_rem_q & align_mask_s) != LEN_ZERO);

        // Buffer level the scheduler sees once the finishing burst is counted.
        case (state_q)
            ST_WAIT_LAST_READ:  fill_sched_s = fill_q + burst_q;
            ST_WAIT_LAST_WRITE: fill_sched_s = fill_q - burst_q;
            default:            fill_sched_s = fill_q;
        endcase

        wr_go_s = (wr_rem_q != LEN_ZERO) && (fill_sched_s >= wr_burst_s);
        rd_go_s = (rd_rem_q != LEN_ZERO)
               && ((CNT_W'(CAP) - fill_sched_s) >= rd_burst_s);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        en_prev_d    = ch_enable_i;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        rd_size_d    = rd_size_q;
        wr_size_d    = wr_size_q;
        rd_bsize_d   = rd_bsize_q;
        wr_bsize_d   = wr_bsize_q;
        rd_incr_d    = rd_incr_q;
        wr_incr_d    = wr_incr_q;
        rd_rem_d     = rd_rem_q;
        wr_rem_d     = wr_rem_q;
        fill_d       = fill_q;
        burst_d      = burst_q;
        lenght_d     = lenght_q;
        size_d       = size_q;
        incr_d       = incr_q;
        mode_d       = mode_q;
        ch_error_d   = 1'b0;
        do_sched_s   = 1'b0;
        abort_done_s = 1'b0;
`ifdef V_CHANNEL_ABORT_EN
        pend_d       = pend_q;
        pend_mode_d  = pend_mode_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ch_enable_i && !en_prev_q) begin
                    rd_addr_d  = ch_rd_addr_i;
                    wr_addr_d  = ch_wr_addr_i;
                    rd_size_d  = ch_rd_size_i;
                    wr_size_d  = ch_wr_size_i;
                    rd_bsize_d = ch_rd_bsize_i;
                    wr_bsize_d = ch_wr_bsize_i;
                    rd_incr_d  = ch_rd_incr_i;
                    wr_incr_d  = ch_wr_incr_i;
                    rd_rem_d   = ch_data_len_i;
                    wr_rem_d   = ch_data_len_i;
                    fill_d     = CNT_ZERO;
                    state_d    = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cfg_bad_s) begin
                    ch_error_d = 1'b1;
                    state_d    = ST_BUS_ERROR;
                end else begin
                    do_sched_s = 1'b1;
                end
            end
            ST_READ: begin
                if (i_resp_i) begin
                    state_d = ST_BUS_ERROR;
                end else if (i_next_i) begin
                    state_d  = ST_WAIT_LAST_READ;
                    rd_rem_d = rd_rem_q - LEN_W'(burst_q);
                    if (rd_incr_q) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(burst_q);
                    end else begin
                        rd_addr_d = rd_addr_q;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WAIT_LAST_READ: begin
                if (i_resp_i) begin
                    state_d = ST_BUS_ERROR;
                end else if (i_last_i) begin
                    fill_d     = fill_sched_s;
                    do_sched_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_LAST_READ;
                end
            end
            ST_WRITE: begin
                if (i_resp_i) begin
                    state_d = ST_BUS_ERROR;
                end else if (i_next_i) begin
                    state_d  = ST_WAIT_LAST_WRITE;
                    wr_rem_d = wr_rem_q - LEN_W'(burst_q);
                    if (wr_incr_q) begin
                        wr_addr_d = wr_addr_q + ADDR_W'(burst_q);
                    end else begin
                        wr_addr_d = wr_addr_q;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_LAST_WRITE: begin
                if (i_resp_i) begin
                    state_d = ST_BUS_ERROR;
                end else if (i_last_write_i) begin
                    fill_d     = fill_sched_s;
                    do_sched_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_LAST_WRITE;
                end
            end
            ST_DONE:      state_d = ST_IDLE;
            ST_BUS_ERROR: state_d = ST_IDLE;
`ifdef V_CHANNEL_ABORT_EN
            ST_ABORT: begin
                if (!pend_q || (pend_mode_q ? i_last_write_i : i_last_i)) begin
                    abort_done_s = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_ABORT;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Scheduler: drain to the writer first, then refill, then finish.
        if (do_sched_s) begin
            if (wr_go_s) begin
                state_d  = ST_WRITE;
                burst_d  = wr_burst_s;
                lenght_d = wr_burst_s >> wr_size_q;
                size_d   = wr_size_q;
                incr_d   = wr_incr_q;
                mode_d   = 1'b1;
            end else if (rd_go_s) begin
                state_d  = ST_READ;
                burst_d  = rd_burst_s;
                lenght_d = rd_burst_s >> rd_size_q;
                size_d   = rd_size_q;
                incr_d   = rd_incr_q;
                mode_d   = 1'b0;
            end else if (wr_rem_q == LEN_ZERO) begin
                state_d = ST_DONE;
            end else begin
                // Neither side can make progress: stop instead of hanging.
                state_d = ST_BUS_ERROR;
            end
        end else begin
            burst_d = burst_d;
        end

`ifdef V_CHANNEL_ABORT_EN
        // Abort wins over everything else; remember whether a burst is still
        // in flight so its last beat can be awaited.
        if (ch_abort_i && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
            state_d     = ST_ABORT;
            ch_error_d  = 1'b0;
            pend_d      = ((state_q == ST_WAIT_LAST_READ)  && !i_last_i)
                       || ((state_q == ST_WAIT_LAST_WRITE) && !i_last_write_i);
            pend_mode_d = (state_q == ST_WAIT_LAST_WRITE);
        end else begin
            pend_mode_d = pend_mode_d;
        end
`endif

        rush_read_d  = (state_d == ST_READ);
        rush_write_d = (state_d == ST_WRITE);
        ready_d      = (state_d == ST_IDLE);
        intr_d       = (state_d == ST_DONE) || abort_done_s;
        bus_err_d    = (state_d == ST_BUS_ERROR) || abort_done_s;
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            en_prev_q    <= 1'b0;
            rd_addr_q    <= {ADDR_W{1'b0}};
            wr_addr_q    <= {ADDR_W{1'b0}};
            rd_size_q    <= 2'd0;
            wr_size_q    <= 2'd0;
            rd_bsize_q   <= 3'd0;
            wr_bsize_q   <= 3'd0;
            rd_incr_q    <= 1'b0;
            wr_incr_q    <= 1'b0;
            rd_rem_q     <= LEN_ZERO;
            wr_rem_q     <= LEN_ZERO;
            fill_q       <= CNT_ZERO;
            burst_q      <= CNT_ZERO;
            rush_read_q  <= 1'b0;
            rush_write_q <= 1'b0;
            lenght_q     <= CNT_ZERO;
            size_q       <= 2'd0;
            incr_q       <= 1'b0;
            mode_q       <= 1'b0;
            ch_error_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            intr_q       <= 1'b0;
            ready_q      <= 1'b1;
`ifdef V_CHANNEL_ABORT_EN
            pend_q       <= 1'b0;
            pend_mode_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            en_prev_q    <= en_prev_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            rd_size_q    <= rd_size_d;
            wr_size_q    <= wr_size_d;
            rd_bsize_q   <= rd_bsize_d;
            wr_bsize_q   <= wr_bsize_d;
            rd_incr_q    <= rd_incr_d;
            wr_incr_q    <= wr_incr_d;
            rd_rem_q     <= rd_rem_d;
            wr_rem_q     <= wr_rem_d;
            fill_q       <= fill_d;
            burst_q      <= burst_d;
            rush_read_q  <= rush_read_d;
            rush_write_q <= rush_write_d;
            lenght_q     <= lenght_d;
            size_q       <= size_d;
            incr_q       <= incr_d;
            mode_q       <= mode_d;
            ch_error_q   <= ch_error_d;
            bus_err_q    <= bus_err_d;
            intr_q       <= intr_d;
            ready_q      <= ready_d;
`ifdef V_CHANNEL_ABORT_EN
            pend_q       <= pend_d;
            pend_mode_q  <= pend_mode_d;
`endif
        end
    end

    assign rush_read_o    = rush_read_q;
    assign rush_write_o   = rush_write_q;
    assign i_rd_addr_o    = rd_addr_q;
    assign i_wr_addr_o    = wr_addr_q;
    assign i_lenght_o     = lenght_q;
    assign i_size_o       = size_q;
    assign i_incr_o       = incr_q;
    assign i_mode_o       = mode_q;
    assign ch_error_o     = ch_error_q;
    assign ch_bus_error_o = bus_err_q;
    assign ch_interrupt_o = intr_q;
    assign ready          = ready_q;

endmodule
